// File: rtl/pipemem_io.sv
`default_nettype none
// ============================================================================
// Module   : pipemem_io
// Brief    : MEM stage of the pipelined CPU. Data RAM with asynchronous read,
//            memory-mapped switch inputs (two-flop synchronized), three
//            output registers and a free-running, loadable cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipemem_io #(
  parameter int ADDR_W = 5,
  parameter int IN_W   = 5
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            mwmem,
  input  logic [31:0]     malu,
  input  logic [31:0]     mb,
  input  logic [IN_W-1:0] in_port0,
  input  logic [IN_W-1:0] in_port1,
  output logic [31:0]     mmo,
  output logic [31:0]     out_port0,
  output logic [31:0]     out_port1,
  output logic [31:0]     out_port2
);

  // I/O register word indices (byte address bits [6:2] with bit 7 set)
  localparam logic [4:0] IDX_IN0  = 5'd0;   // 0x80
  localparam logic [4:0] IDX_IN1  = 5'd1;   // 0x84
  localparam logic [4:0] IDX_CNT  = 5'd2;   // 0x88
  localparam logic [4:0] IDX_OUT0 = 5'd16;  // 0xC0
  localparam logic [4:0] IDX_OUT1 = 5'd17;  // 0xC4
  localparam logic [4:0] IDX_OUT2 = 5'd18;  // 0xC8

  logic [31:0]     ram [2**ADDR_W];
  logic            io_sel;
  logic [4:0]      io_idx;
  logic [ADDR_W-1:0] ram_idx;
  logic            ram_we;
  logic            io_we;
  logic [IN_W-1:0] sync0_a, sync0_b;
  logic [IN_W-1:0] sync1_a, sync1_b;
  logic [31:0]     cycle_cnt;
  logic            unused_bits;

  assign io_sel  = malu[7];
  assign io_idx  = malu[6:2];
  assign ram_idx = malu[ADDR_W+1:2];
  assign ram_we  = mwmem & ~io_sel;
  assign io_we   = mwmem & io_sel;

  // Byte-lane and upper address bits are intentionally ignored (word aliasing)
  assign unused_bits = ^{malu[31:8], malu[1:0]};

  // RAM write: not reset, but a store is blocked while reset is held low
  always_ff @(posedge clock) begin
    if (ram_we && resetn) begin
      ram[ram_idx] <= mb;
    end
  end

  // Two-flop synchronizers for the asynchronous switch inputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync0_a <= '0;
      sync0_b <= '0;
      sync1_a <= '0;
      sync1_b <= '0;
    end else begin
      sync0_a <= in_port0;
      sync0_b <= sync0_a;
      sync1_a <= in_port1;
      sync1_b <= sync1_a;
    end
  end

  // Output registers: full-word store from mb
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_port0 <= '0;
      out_port1 <= '0;
      out_port2 <= '0;
    end else if (io_we) begin
      if (io_idx == IDX_OUT0) out_port0 <= mb;
      if (io_idx == IDX_OUT1) out_port1 <= mb;
      if (io_idx == IDX_OUT2) out_port2 <= mb;
    end
  end

  // Cycle counter: a store wins over the increment; wraps naturally
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cycle_cnt <= '0;
    end else if (io_we && (io_idx == IDX_CNT)) begin
      cycle_cnt <= mb;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  // Load data mux: RAM or I/O, independent of mwmem
  always_comb begin
    mmo = 32'd0;
    if (!io_sel) begin
      mmo = ram[ram_idx];
    end else begin
      case (io_idx)
        IDX_IN0:  mmo = {{(32-IN_W){1'b0}}, sync0_b};
        IDX_IN1:  mmo = {{(32-IN_W){1'b0}}, sync1_b};
        IDX_CNT:  mmo = cycle_cnt;
        IDX_OUT0: mmo = out_port0;
        IDX_OUT1: mmo = out_port1;
        IDX_OUT2: mmo = out_port2;
        default:  mmo = 32'd0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipemem_io.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipemem_io
// Brief    : Directed, table-driven self-checking bench for pipemem_io.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipemem_io;

  logic        clock;
  logic        resetn;
  logic        mwmem;
  logic [31:0] malu;
  logic [31:0] mb;
  logic [4:0]  in_port0;
  logic [4:0]  in_port1;
  logic [31:0] mmo;
  logic [31:0] out_port0;
  logic [31:0] out_port1;
  logic [31:0] out_port2;

  int n_checks = 0;
  int n_fail   = 0;

  pipemem_io #(.ADDR_W(5), .IN_W(5)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .mwmem     (mwmem),
    .malu      (malu),
    .mb        (mb),
    .in_port0  (in_port0),
    .in_port1  (in_port1),
    .mmo       (mmo),
    .out_port0 (out_port0),
    .out_port1 (out_port1),
    .out_port2 (out_port2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        chk_mmo;
    logic [31:0] exp_mmo;
    logic        chk_out;
    logic [31:0] o0;
    logic [31:0] o1;
    logic [31:0] o2;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] data,
                     input logic chk_mmo, input logic [31:0] exp_mmo, input logic chk_out,
                     input logic [31:0] o0, input logic [31:0] o1, input logic [31:0] o2);
    vec_t v;
    v.we = we; v.addr = addr; v.data = data;
    v.chk_mmo = chk_mmo; v.exp_mmo = exp_mmo;
    v.chk_out = chk_out; v.o0 = o0; v.o1 = o1; v.o2 = o2;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_true(input string name, input logic cond, input logic [31:0] act);
    n_checks++;
    if (cond !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: condition false, observed 0x%08h", name, act);
    end
  endtask

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    resetn   = 1'b0;
    mwmem    = 1'b0;
    malu     = 32'h88;
    mb       = 32'd0;
    in_port0 = '0;
    in_port1 = '0;

    // Reset state before any clock edge
    #1;
    check("reset_out0", out_port0, 32'd0);
    check("reset_out1", out_port1, 32'd0);
    check("reset_out2", out_port2, 32'd0);
    check("reset_cnt",  mmo,       32'd0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    #1;
    check("cnt_before_first_edge", mmo, 32'd0);
    @(negedge clock); #1;
    check("cnt_after_first_edge", mmo, 32'd1);

    // we, addr, data, chk_mmo, exp_mmo, chk_out, o0, o1, o2
    add(1, 32'h14,  32'hDEADBEEF, 0, 32'h0,        1, 0, 0, 0);
    add(0, 32'h14,  32'h0,        1, 32'hDEADBEEF, 1, 0, 0, 0);
    add(1, 32'h10,  32'h12345678, 0, 32'h0,        0, 0, 0, 0);
    add(0, 32'h10,  32'h0,        1, 32'h12345678, 0, 0, 0, 0);
    add(0, 32'h14,  32'h0,        1, 32'hDEADBEEF, 0, 0, 0, 0);
    add(1, 32'h08,  32'h1,        0, 32'h0,        0, 0, 0, 0);
    add(1, 32'h08,  32'h2,        1, 32'h1,        0, 0, 0, 0);
    add(0, 32'h08,  32'h0,        1, 32'h2,        0, 0, 0, 0);
    add(1, 32'hC4,  32'hAA,       1, 32'h0,        1, 0, 0, 0);
    add(0, 32'hC4,  32'h0,        1, 32'hAA,       1, 0, 32'hAA, 0);
    add(1, 32'hCC,  32'h77,       1, 32'h0,        1, 0, 32'hAA, 0);
    add(0, 32'hCC,  32'h0,        1, 32'h0,        1, 0, 32'hAA, 0);
    add(1, 32'hC0,  32'h11,       1, 32'h0,        1, 0, 32'hAA, 0);
    add(1, 32'hC8,  32'h22,       1, 32'h0,        1, 32'h11, 32'hAA, 0);
    add(0, 32'hC8,  32'h0,        1, 32'h22,       1, 32'h11, 32'hAA, 32'h22);
    add(1, 32'h80,  32'hFFFF,     1, 32'h0,        0, 0, 0, 0);
    add(0, 32'h80,  32'h0,        1, 32'h0,        0, 0, 0, 0);
    add(1, 32'h94,  32'hBAD,      1, 32'h0,        0, 0, 0, 0);
    add(0, 32'h94,  32'h0,        1, 32'h0,        0, 0, 0, 0);
    add(0, 32'h14,  32'h0,        1, 32'hDEADBEEF, 0, 0, 0, 0);
    add(1, 32'h114, 32'hCAFEF00D, 1, 32'hDEADBEEF, 0, 0, 0, 0);
    add(0, 32'h17,  32'h0,        1, 32'hCAFEF00D, 1, 32'h11, 32'hAA, 32'h22);
    add(1, 32'h88,  32'hFFFFFFFE, 0, 32'h0,        0, 0, 0, 0);
    add(0, 32'h88,  32'h0,        1, 32'hFFFFFFFE, 0, 0, 0, 0);
    add(0, 32'h88,  32'h0,        1, 32'hFFFFFFFF, 0, 0, 0, 0);
    add(0, 32'h88,  32'h0,        1, 32'h0,        0, 0, 0, 0);
    add(1, 32'h88,  32'h100,      1, 32'h1,        0, 0, 0, 0);
    add(0, 32'h88,  32'h0,        1, 32'h100,      0, 0, 0, 0);
    add(0, 32'h88,  32'h0,        1, 32'h101,      0, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clock);
      mwmem = vecs[i].we;
      malu  = vecs[i].addr;
      mb    = vecs[i].data;
      #1;
      if (vecs[i].chk_mmo) check($sformatf("vec%0d_mmo", i), mmo, vecs[i].exp_mmo);
      if (vecs[i].chk_out) begin
        check($sformatf("vec%0d_out0", i), out_port0, vecs[i].o0);
        check($sformatf("vec%0d_out1", i), out_port1, vecs[i].o1);
        check($sformatf("vec%0d_out2", i), out_port2, vecs[i].o2);
      end
    end

    // Synchronizer latency: change just after edge N, visible after edge N+2
    @(negedge clock);
    mwmem = 1'b0;
    malu  = 32'h80;
    @(posedge clock); #1;
    in_port0 = 5'h15;
    #1;
    check("sync_after_N", mmo, 32'h0);
    @(posedge clock); #1;
    check("sync_after_N1", mmo, 32'h0);
    @(posedge clock); #1;
    check("sync_after_N2", mmo, 32'h15);
    in_port1 = 5'h0A;
    malu     = 32'h84;
    repeat (2) @(posedge clock);
    #1;
    check("sync_in1", mmo, 32'h0A);

    // Asynchronous reset mid-run
    @(negedge clock);
    mwmem = 1'b1;
    malu  = 32'hC8;
    mb    = 32'h55;
    @(negedge clock);
    mwmem = 1'b0;
    malu  = 32'h88;
    repeat (1000) @(negedge clock);
    #1;
    check("pre_reset_out2", out_port2, 32'h55);
    check_true("pre_reset_cnt_large", mmo > 32'd1000, mmo);
    @(posedge clock); #2;
    resetn = 1'b0;
    #1;
    check("async_out0", out_port0, 32'd0);
    check("async_out1", out_port1, 32'd0);
    check("async_out2", out_port2, 32'd0);
    check("async_cnt",  mmo,       32'd0);
    malu = 32'h80;
    #1;
    check("async_sync", mmo, 32'd0);
    mwmem = 1'b1;
    malu  = 32'h14;
    mb    = 32'h0BADBAD0;
    @(posedge clock); #1;
    malu = 32'hC0;
    mb   = 32'h99;
    @(posedge clock); #1;
    mwmem = 1'b0;
    malu  = 32'h88;
    #1;
    check("cnt_held_in_reset", mmo, 32'd0);
    check("out0_blocked_in_reset", out_port0, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    malu   = 32'h14;
    #1;
    check("ram_blocked_in_reset", mmo, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipemem_io.md
Name: pipemem_io

Overview:
- MEM stage of the pipelined CPU. Sits between the EX/MEM register and the MEM/WB register.
- Accepts the EX/MEM address (malu), store data (mb) and store enable (mwmem).
- Performs the data-memory or memory-mapped I/O access and produces mmo, which the MEM/WB register captures on the next rising clock edge.
- Owns the board I/O: synchronized switch inputs, LED/HEX output registers and a free-running cycle counter.

Parameters:
- ADDR_W, 5, word-address width of the data RAM (2^ADDR_W 32-bit words; default 32 words = byte addresses 0x00-0x7C).
- IN_W, 5, width of each input port (switch group).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- mwmem  input  1  store enable from EX/MEM.
- malu  input  32  byte address from EX/MEM ALU result.
- mb  input  32  store data from EX/MEM.
- in_port0  input  IN_W  switch group 0, asynchronous to clock.
- in_port1  input  IN_W  switch group 1, asynchronous to clock.
- mmo  output  32  load data to MEM/WB; combinational from malu and current state.
- out_port0  output  32  output register 0.
- out_port1  output  32  output register 1.
- out_port2  output  32  output register 2.

Behaviour:
- Decode:
  - io_sel = malu[7]. malu[1:0] and malu[31:8] are ignored (word accesses only; aliasing accepted).
  - RAM word index = malu[ADDR_W+1:2] when io_sel=0.
  - With ADDR_W>5, RAM index bits above bit 6 are still taken from malu, but io_sel=1 always selects I/O.
- I/O map (io_sel=1, decoded on malu[6:2]), byte addresses:
  - 0x80: read = zero-extended synchronized in_port0; writes ignored.
  - 0x84: read = zero-extended synchronized in_port1; writes ignored.
  - 0x88: read = cycle counter; write loads counter with mb.
  - 0xC0 / 0xC4 / 0xC8: read/write out_port0 / out_port1 / out_port2.
  - All other I/O addresses: read 0, write ignored.
- RAM:
  - Asynchronous read; synchronous write on rising edge when mwmem=1 and io_sel=0.
  - Contents are not affected by resetn and are undefined at power-up.
  - Read of the address being written in the same cycle returns old data. New data is visible from the cycle after the edge.
- Writes: an I/O write takes effect on the rising edge when mwmem=1 and the address decodes to a writable register. mb is stored unmodified (full 32 bits).
- mmo:
  - Purely combinational, zero latency, valid within the same cycle as malu.
  - mmo is driven regardless of mwmem. The WB mux decides use via wm2reg.
- Input synchronizers:
  - Two flops per input port, both reset to 0.
  - A pin change is visible on mmo 2 rising edges later (readable in the cycle after the second edge).
- Cycle counter:
  - 32-bit; increments by 1 every rising edge; wraps 0xFFFFFFFF -> 0x00000000.
  - A write in the same cycle takes priority over the increment: the counter becomes mb exactly, then resumes incrementing from mb on the following edge.
- Reset (asynchronous, resetn=0):
  - out_port0..2 = 0, counter = 0, synchronizer flops = 0, immediately and independent of clock.
  - While resetn=0: all writes are blocked (RAM included) and the counter holds at 0.
  - After deassertion, the counter reads 1 following the first rising edge.
  - Reset asserted mid-store: the store is discarded unless the edge completed before assertion.
- No handshake and no stall: each access completes in one cycle. The pipeline never waits on this block.

Test Plan:
- Reset then store: resetn low 2 cycles, then high. Check out_port0..2 = 0. Store mb=0xDEADBEEF to 0x14, next cycle load 0x14 -> mmo=0xDEADBEEF. Load 0x10 after storing 0x12345678 there -> 0x12345678; 0x14 unchanged.
- Read-during-write: RAM[0x08]=0x1, store 0x2 to 0x08. In the store cycle mmo=0x1; in the next cycle mmo=0x2.
- Output registers: store 0x000000AA to 0xC4 -> out_port1=0xAA after the edge, out_port0/2 unchanged, load 0xC4 -> 0xAA. Store to 0xCC -> no output changes, load 0xCC -> 0.
- Synchronizer latency: in_port0 0 -> 5'h15 just after edge N, address 0x80 held. mmo=0 through edge N+1; mmo=0x00000015 after edge N+2.
- Counter wrap and priority: store 0xFFFFFFFE to 0x88. Next cycle reads 0xFFFFFFFE, then 0xFFFFFFFF, then 0x00000000. Write 0x100 while incrementing -> reads exactly 0x100 the cycle after the edge.
- Async reset mid-run: out_port2=0x55 and counter ~1000, pulse resetn low between edges. Outputs and counter read 0 before any clock edge. A RAM store with resetn low leaves RAM unchanged.
